// File: rtl/pkt_con_arb.sv
// Per-node ingress arbiter: merges N_X + N_Y point-to-point links into one registered stream.
// Two QoS classes, round-robin within each class, with a starvation counter that lets low requests through.
module pkt_con_arb #(
  parameter int unsigned N_X        = 7,
  parameter int unsigned N_Y        = 7,
  parameter int unsigned SRC_W      = 6,
  parameter int unsigned TGT_W      = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_X-1:0]        x_vld,
  input  logic [N_X-1:0]        x_qos,
  input  logic [N_X-1:0]        x_type,
  input  logic [N_X*SRC_W-1:0]  x_src,
  input  logic [N_X*TGT_W-1:0]  x_tgt,
  input  logic [N_X*DATA_W-1:0] x_data,
  output logic [N_X-1:0]        x_rdy,
  input  logic [N_Y-1:0]        y_vld,
  input  logic [N_Y-1:0]        y_qos,
  input  logic [N_Y-1:0]        y_type,
  input  logic [N_Y*SRC_W-1:0]  y_src,
  input  logic [N_Y*TGT_W-1:0]  y_tgt,
  input  logic [N_Y*DATA_W-1:0] y_data,
  output logic [N_Y-1:0]        y_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_qos,
  output logic                  out_type,
  output logic [SRC_W-1:0]      out_src,
  output logic [TGT_W-1:0]      out_tgt,
  output logic [DATA_W-1:0]     out_data,
  output logic [3:0]            out_port
);

  localparam int unsigned N      = N_X + N_Y;
  localparam int unsigned PORT_W = 4;
  localparam int unsigned CNT_W  = 4;

  logic [N-1:0]        req_c, qos_all_c, type_all_c, hi_req_c, lo_req_c, cls_req_c, rdy_c;
  logic                load_c, sel_lo_c, found_c, hs_c;
  logic [PORT_W-1:0]   ptr_c, gnt_c, gnt_nxt_c, idx_c;
  logic [PORT_W:0]     sum_c;
  logic [SRC_W-1:0]    sel_src_c;
  logic [TGT_W-1:0]    sel_tgt_c;
  logic [DATA_W-1:0]   sel_data_c;

  logic                out_vld_q, out_vld_d;
  logic                out_qos_q, out_qos_d;
  logic                out_type_q, out_type_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;
  logic [TGT_W-1:0]    out_tgt_q, out_tgt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [PORT_W-1:0]   out_port_q, out_port_d;
  logic [PORT_W-1:0]   hi_ptr_q, hi_ptr_d;
  logic [PORT_W-1:0]   lo_ptr_q, lo_ptr_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

  // Class choice and round-robin scan from the class pointer, wrapping at N.
  always_comb begin
    req_c      = {y_vld, x_vld};
    qos_all_c  = {y_qos, x_qos};
    type_all_c = {y_type, x_type};
    hi_req_c   = req_c & qos_all_c;
    lo_req_c   = req_c & ~qos_all_c;
    load_c     = ~out_vld_q | out_rdy;
    sel_lo_c   = ((starve_cnt_q == CNT_W'(STARVE_MAX)) && (|lo_req_c)) || !(|hi_req_c);
    cls_req_c  = sel_lo_c ? lo_req_c : hi_req_c;
    ptr_c      = sel_lo_c ? lo_ptr_q : hi_ptr_q;
    found_c    = 1'b0;
    gnt_c      = '0;
    sum_c      = '0;
    idx_c      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_c = {1'b0, ptr_c} + (PORT_W+1)'(k);
      if (sum_c >= (PORT_W+1)'(N)) sum_c = sum_c - (PORT_W+1)'(N);
      idx_c = sum_c[PORT_W-1:0];
      if (!found_c && cls_req_c[idx_c]) begin
        found_c = 1'b1;
        gnt_c   = idx_c;
      end
    end
    hs_c      = found_c & load_c;
    gnt_nxt_c = (gnt_c == PORT_W'(N-1)) ? '0 : gnt_c + PORT_W'(1);
    rdy_c     = '0;
    if (hs_c && rst_n) rdy_c[gnt_c] = 1'b1;
  end

  assign x_rdy = rdy_c[N_X-1:0];
  assign y_rdy = rdy_c[N-1:N_X];

  // Field mux for the granted link.
  always_comb begin
    sel_src_c  = '0;
    sel_tgt_c  = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < N_X; i++) begin
      if (gnt_c == PORT_W'(i)) begin
        sel_src_c  = x_src[i*SRC_W +: SRC_W];
        sel_tgt_c  = x_tgt[i*TGT_W +: TGT_W];
        sel_data_c = x_data[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned i = 0; i < N_Y; i++) begin
      if (gnt_c == PORT_W'(N_X + i)) begin
        sel_src_c  = y_src[i*SRC_W +: SRC_W];
        sel_tgt_c  = y_tgt[i*TGT_W +: TGT_W];
        sel_data_c = y_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_vld_d    = out_vld_q;
    out_qos_d    = out_qos_q;
    out_type_d   = out_type_q;
    out_src_d    = out_src_q;
    out_tgt_d    = out_tgt_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    hi_ptr_d     = hi_ptr_q;
    lo_ptr_d     = lo_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (hs_c) begin
      out_vld_d  = 1'b1;
      out_qos_d  = qos_all_c[gnt_c];
      out_type_d = type_all_c[gnt_c];
      out_src_d  = sel_src_c;
      out_tgt_d  = sel_tgt_c;
      out_data_d = sel_data_c;
      out_port_d = gnt_c;
      if (sel_lo_c) begin
        lo_ptr_d     = gnt_nxt_c;
        starve_cnt_d = '0;
      end else begin
        hi_ptr_d = gnt_nxt_c;
        // Count high grants only while a low request is actually waiting.
        if (|lo_req_c) begin
          if (starve_cnt_q != CNT_W'(STARVE_MAX)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
          starve_cnt_d = '0;
        end
      end
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q    <= 1'b0;
      out_qos_q    <= 1'b0;
      out_type_q   <= 1'b0;
      out_src_q    <= '0;
      out_tgt_q    <= '0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      hi_ptr_q     <= '0;
      lo_ptr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_qos_q    <= out_qos_d;
      out_type_q   <= out_type_d;
      out_src_q    <= out_src_d;
      out_tgt_q    <= out_tgt_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      hi_ptr_q     <= hi_ptr_d;
      lo_ptr_q     <= lo_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_qos  = out_qos_q;
  assign out_type = out_type_q;
  assign out_src  = out_src_q;
  assign out_tgt  = out_tgt_q;
  assign out_data = out_data_q;
  assign out_port = out_port_q;

endmodule

// File: tb/tb_pkt_con_arb.sv
// Scoreboard bench for pkt_con_arb: directed link stimulus pushes expected packets, a negedge monitor pops them.
module tb_pkt_con_arb;

  localparam int N_X = 7;
  localparam int N_Y = 7;
  localparam int N   = N_X + N_Y;

  logic clk, rst_n, out_rdy;
  logic [N_X-1:0] x_vld, x_qos, x_type, x_rdy;
  logic [N_Y-1:0] y_vld, y_qos, y_type, y_rdy;
  logic [N_X*6-1:0]  x_src, x_tgt;
  logic [N_Y*6-1:0]  y_src, y_tgt;
  logic [N_X*32-1:0] x_data;
  logic [N_Y*32-1:0] y_data;
  logic        out_vld, out_qos, out_type;
  logic [5:0]  out_src, out_tgt;
  logic [31:0] out_data;
  logic [3:0]  out_port;
  logic [N-1:0] rdy_all;

  logic        vld_a [N];
  logic        qos_a [N];
  logic        typ_a [N];
  logic [5:0]  src_a [N];
  logic [5:0]  tgt_a [N];
  logic [31:0] data_a[N];

  typedef struct packed {
    logic [3:0]  port;
    logic        qos;
    logic        typ;
    logic [5:0]  src;
    logic [5:0]  tgt;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pkt_con_arb dut (
    .clk(clk), .rst_n(rst_n),
    .x_vld(x_vld), .x_qos(x_qos), .x_type(x_type), .x_src(x_src), .x_tgt(x_tgt), .x_data(x_data), .x_rdy(x_rdy),
    .y_vld(y_vld), .y_qos(y_qos), .y_type(y_type), .y_src(y_src), .y_tgt(y_tgt), .y_data(y_data), .y_rdy(y_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_qos(out_qos), .out_type(out_type),
    .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data), .out_port(out_port)
  );

  assign rdy_all = {y_rdy, x_rdy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_X; i++) begin
      x_vld[i] = vld_a[i];
      x_qos[i] = qos_a[i];
      x_type[i] = typ_a[i];
      x_src[i*6 +: 6] = src_a[i];
      x_tgt[i*6 +: 6] = tgt_a[i];
      x_data[i*32 +: 32] = data_a[i];
    end
    for (int i = 0; i < N_Y; i++) begin
      y_vld[i] = vld_a[N_X+i];
      y_qos[i] = qos_a[N_X+i];
      y_type[i] = typ_a[N_X+i];
      y_src[i*6 +: 6] = src_a[N_X+i];
      y_tgt[i*6 +: 6] = tgt_a[N_X+i];
      y_data[i*32 +: 32] = data_a[N_X+i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.port = 4'(i);
    e.qos  = qos_a[i];
    e.typ  = typ_a[i];
    e.src  = src_a[i];
    e.tgt  = tgt_a[i];
    e.data = data_a[i];
    sb.push_back(e);
  endtask

  task automatic clear_vld();
    for (int i = 0; i < N; i++) vld_a[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: each cycle a packet is taken downstream it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got port %0d data %0h, expected nothing", out_port, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_port", 64'(out_port), 64'(e.port));
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_src",  64'(out_src),  64'(e.src));
        chk("out_tgt",  64'(out_tgt),  64'(e.tgt));
        chk("out_qos",  64'(out_qos),  64'(e.qos));
        chk("out_type", 64'(out_type), 64'(e.typ));
      end
    end
  end

  int qos_seq[10] = '{7, 7, 7, 7, 7, 7, 7, 7, 0, 7};

  initial begin
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      vld_a[i]  = 1'b0;
      qos_a[i]  = 1'b0;
      typ_a[i]  = 1'(i % 2);
      src_a[i]  = 6'(i + 3);
      tgt_a[i]  = 6'(50 - i);
      data_a[i] = 32'hC0DE_0000 + 32'(i * 17);
    end

    // Reset: outputs cleared and no ready even with a valid link.
    vld_a[3] = 1'b1;
    tick();
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_port", 64'(out_port), 64'd0);
    chk("rst_rdy", 64'(rdy_all), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    clear_vld();
    tick();
    rst_n = 1'b1;

    // Single low request on link 2.
    data_a[2] = 32'h0000_00A5;
    vld_a[2]  = 1'b1;
    #1;
    chk("single_x_rdy", 64'(x_rdy), 64'h04);
    chk("single_y_rdy", 64'(y_rdy), 64'h00);
    push_exp(2);
    tick();
    vld_a[2] = 1'b0;
    chk("single_out_data", 64'(out_data), 64'hA5);
    chk("single_lo_ptr", 64'(dut.lo_ptr_q), 64'd3);
    tick();
    tick();

    // Round-robin across all 14 low links from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) vld_a[i] = 1'b1;
    #1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("rr_rdy_%0d", k), 64'(rdy_all), 64'(onehot(k % N)));
      push_exp(k % N);
      tick();
    end
    clear_vld();
    tick();
    tick();

    // QoS priority with starvation relief for the low link.
    do_reset();
    qos_a[7] = 1'b1;
    vld_a[7] = 1'b1;
    vld_a[0] = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("qos_rdy_%0d", k), 64'(rdy_all), 64'(onehot(qos_seq[k])));
      push_exp(qos_seq[k]);
      tick();
      if (k == 7) chk("qos_starve_sat", 64'(dut.starve_cnt_q), 64'd8);
      if (k == 8) chk("qos_starve_clr", 64'(dut.starve_cnt_q), 64'd0);
    end
    clear_vld();
    qos_a[7] = 1'b0;
    tick();
    tick();

    // Backpressure: held packet stays put, no grants, pointers frozen.
    do_reset();
    out_rdy  = 1'b0;
    vld_a[0] = 1'b1;
    #1;
    chk("bp_first_rdy", 64'(rdy_all), 64'(onehot(0)));
    push_exp(0);
    tick();
    vld_a[0] = 1'b0;
    for (int i = 1; i <= 4; i++) vld_a[i] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rdy", 64'(rdy_all), 64'd0);
      chk("bp_out_vld", 64'(out_vld), 64'd1);
      chk("bp_out_port", 64'(out_port), 64'd0);
      chk("bp_out_data", 64'(out_data), 64'(data_a[0]));
      chk("bp_lo_ptr", 64'(dut.lo_ptr_q), 64'd1);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_resume_rdy", 64'(rdy_all), 64'(onehot(1)));
    push_exp(1);
    tick();
    clear_vld();
    chk("bp_next_port", 64'(out_port), 64'd1);
    tick();
    tick();

    // Pointer wrap 13 -> 0.
    do_reset();
    vld_a[12] = 1'b1;
    #1;
    chk("wrap_rdy12", 64'(rdy_all), 64'(onehot(12)));
    push_exp(12);
    tick();
    vld_a[12] = 1'b0;
    chk("wrap_ptr13", 64'(dut.lo_ptr_q), 64'd13);
    vld_a[13] = 1'b1;
    vld_a[0]  = 1'b1;
    #1;
    chk("wrap_rdy13", 64'(rdy_all), 64'(onehot(13)));
    push_exp(13);
    tick();
    vld_a[13] = 1'b0;
    #1;
    chk("wrap_rdy0", 64'(rdy_all), 64'(onehot(0)));
    push_exp(0);
    tick();
    vld_a[0] = 1'b0;
    chk("wrap_ptr1", 64'(dut.lo_ptr_q), 64'd1);
    tick();
    tick();

    // Asynchronous reset while a packet is held under backpressure.
    out_rdy  = 1'b0;
    vld_a[5] = 1'b1;
    #1;
    tick();
    chk("mid_out_vld", 64'(out_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_out_port", 64'(out_port), 64'd0);
    chk("mid_rst_rdy", 64'(rdy_all), 64'd0);
    vld_a[5] = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_hi_ptr", 64'(dut.hi_ptr_q), 64'd0);
    chk("mid_lo_ptr", 64'(dut.lo_ptr_q), 64'd0);
    out_rdy = 1'b1;
    tick();
    tick();

    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_con_arb.md
# pkt_con_arb

Per-node ingress arbiter for the maze mesh. It merges the 14 incoming point-to-point links of one node into a single registered packet stream: 7 X-direction links (same x, other y) and 7 Y-direction links (same y, other x). Selection is two-class: QoS-high requests win over QoS-low requests. Within each class, selection is round-robin, and a starvation counter guarantees QoS-low requests still make progress. It sits on the node's slv side, between the link fabric and the node's ejection/forwarding logic.

## Interface
Parameters:
- N_X, 7, number of X-direction links; requester indices 0..N_X-1.
- N_Y, 7, number of Y-direction links; requester indices N_X..N_X+N_Y-1.
- SRC_W, 6, source id width.
- TGT_W, 6, target id width.
- DATA_W, 32, payload width.
- STARVE_MAX, 8, number of consecutive high grants allowed while a low request waits; range 1..15.

Ports (N = N_X+N_Y = 14 at defaults):
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_vld / y_vld  in  N_X / N_Y  per-link valid.
- x_qos / y_qos  in  N_X / N_Y  per-link QoS; 1 = high.
- x_type / y_type  in  N_X / N_Y  per-link packet type.
- x_src / y_src  in  N_X*SRC_W / N_Y*SRC_W  source ids; link i occupies bits [i*SRC_W +: SRC_W].
- x_tgt / y_tgt  in  N_X*TGT_W / N_Y*TGT_W  target ids, packed the same way.
- x_data / y_data  in  N_X*DATA_W / N_Y*DATA_W  payloads, packed the same way.
- x_rdy / y_rdy  out  N_X / N_Y  per-link ready; at most one bit set across both buses.
- out_vld  out  1  output packet valid.
- out_rdy  in  1  downstream ready.
- out_qos, out_type  out  1 each  fields of the held packet.
- out_src, out_tgt, out_data  out  SRC_W, TGT_W, DATA_W  fields of the held packet.
- out_port  out  4  requester index (0..13) the held packet came from.

## Operation
Request vector:
- req[i] = vld of link i. X links take indices 0..6, Y links take 7..13.
- hi_req = req & qos; lo_req = req & ~qos.

Load and class selection:
- load = ~out_vld | out_rdy.
- Arbitration is combinational each cycle.
- Selected class is LO if starve_cnt == STARVE_MAX and lo_req != 0. Otherwise it is HI if hi_req != 0, else LO.

Requester selection:
- Within the selected class, pick the first set bit scanning upward from that class's pointer (hi_ptr or lo_ptr), inclusive, wrapping 13 → 0.
- Grant a single index g.
- rdy[g] = load. All other rdy bits are 0.
- No grant and no rdy when req == 0.
- A handshake on link g occurs when vld[g] & rdy[g].

On a handshake:
- Output register loads qos, type, src, tgt, data and out_port = g; out_vld <= 1.
- The winning class's pointer <= (g+1) mod 14. The other class's pointer is unchanged.

When there is no handshake:
- If out_rdy is 1, out_vld <= 0.
- Otherwise the output holds, and fields stay stable while out_vld & ~out_rdy.

starve_cnt (4 bits), updated only on a handshake cycle:
- Reset to 0 on a LO grant.
- Increment, saturating at STARVE_MAX, on a HI grant while lo_req != 0.
- Reset to 0 on a HI grant while lo_req == 0.
- Unchanged on cycles without a handshake.

Upstream rules:
- vld must not depend combinationally on rdy.
- Once asserted, vld and the fields hold until the handshake.
- The arbiter may move the grant to another link between cycles. Upstream must tolerate a vld held for several cycles without rdy.

## Timing
- Reset (asynchronous assert, synchronous release): out_vld=0; out_qos, out_type, out_src, out_tgt, out_data, out_port = 0; hi_ptr=0; lo_ptr=0; starve_cnt=0. rdy outputs are 0 while rst_n is low.
- Latency: an input handshake in cycle t gives out_vld=1 with that packet in cycle t+1.
- Throughput: one packet per cycle while out_rdy=1.
- Output full (out_vld & ~out_rdy): load=0, all rdy=0, and no pointer or counter update.
- Simultaneous output drain and new grant: the register is replaced in the same edge with no bubble.
- Reset asserted mid-transfer: the held packet is dropped and all state returns to reset values immediately.
- Pointer wrap: if ptr=13 and the grant is 13, the next ptr is 0.

## Test plan
- Single request: x_vld[2]=1, qos=0, data=0xA5, out_rdy=1. Required: x_rdy[2]=1 in cycle 0; cycle 1 has out_vld=1, out_data=0xA5, out_port=2; lo_ptr=3.
- Round-robin: all 14 links valid with qos=0, out_rdy=1, held for 15 cycles. Required: out_port sequence 0,1,…,13,0; one rdy bit per cycle.
- QoS priority: y_vld[0] (index 7) qos=1 and x_vld[0] qos=0, both held, out_rdy=1. Required: first 8 grants go to port 7, grant 9 goes to port 0, grant 10 goes to port 7, and starve_cnt is 0 after grant 9.
- Backpressure: one packet loaded, then out_rdy=0 for 5 cycles with other links valid. Required: out fields stable, all rdy=0, pointers unchanged. After out_rdy rises, the next packet appears 1 cycle later.
- Wrap: lo_ptr driven to 13 by granting index 12, then req bits 13 and 0 set. Required: grant 13, then grant 0, with lo_ptr reading 1 at the end.
- Reset mid-operation: pull rst_n low while out_vld=1 and out_rdy=0. Required: out_vld=0, out_port=0, all rdy=0 within the same cycle (asynchronous), and pointers at 0 after release.
